// File: rtl/serial_rx_16x.sv
// 16x-oversampled asynchronous serial receiver: start, DATA_BITS data (LSB first), stop.
// Define SERIAL_RX_PARITY_EN to add an even parity bit between data and stop.
module serial_rx_16x #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serialIn,
    output logic [DATA_BITS-1:0] receive_parallel,
    output logic                 char_received,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [OsW-1:0]  OsMid   = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreak
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [OsW-1:0]        os_cnt_q, os_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  char_q, char_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_d;
    logic                  par_mis;
    logic                  rx_s;

    assign sync_d = {sync_q[0], serialIn};
    assign rx_s   = sync_q[1];

`ifdef SERIAL_RX_PARITY_EN
    logic par_mis_q, par_mis_d;
    logic perr_q;

    assign par_mis      = par_mis_q;
    assign parity_error = perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_mis_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_mis_q <= par_mis_d;
            perr_q    <= perr_d;
        end
    end

    // Mismatch is latched in PARITY and consumed in STOP; cleared whenever idle.
    always_comb begin
        par_mis_d = par_mis_q;
        if (state_q == StIdle) begin
            par_mis_d = 1'b0;
        end else if (state_q == StParity && os_cnt_q == OsLast) begin
            par_mis_d = ^{shift_q, rx_s};
        end
    end
`else
    assign par_mis      = 1'b0;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            char_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            char_q    <= char_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        char_d    = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            StIdle: begin
                os_cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (os_cnt_q == OsMid) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (os_cnt_q == OsLast) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        os_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d  = StParity;
`else
                        state_d  = StStop;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            StParity: begin
                if (os_cnt_q == OsLast) begin
                    os_cnt_d = '0;
                    state_d  = StStop;
                end
            end
`endif
            StStop: begin
                if (os_cnt_q == OsLast) begin
                    os_cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end else if (par_mis) begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        data_d  = shift_q;
                        char_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                os_cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                os_cnt_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    assign receive_parallel = data_q;
    assign char_received    = char_q;
    assign frame_error      = ferr_q;
    assign busy             = (state_q != StIdle);

endmodule
